rat_checkpoint_ctrl: RTL and testbench

// Allocates and retires the RAT's shadow checkpoint pages for in-flight branches/jumps. Dispatch

---
 rtl/rat_checkpoint_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_rat_checkpoint_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rat_checkpoint_ctrl.sv
// rat_checkpoint_ctrl
//   Allocates and retires the RAT's shadow checkpoint pages for in-flight
//   branches/jumps. Pages form a circular buffer in program order:
//   - dispatch allocates at the tail,
//   - correctly resolved pages retire in order from the head,
//   - a mispredict restores the RAT from that branch's page and squashes
//     that page and every younger one.
//
// Parameters
//   NUM_PAGES  number of checkpoint pages (power of 2, 2..32)
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   flush_all         drop every checkpoint (exception / mret); beats all inputs
//   alloc_valid       dispatch wants a page this cycle
//   alloc_ready       a page is free (not full)
//   alloc_page        page the next allocation takes (zero-extended)
//   resolve_valid     branch unit resolves one branch
//   resolve_page      page tag of resolved branch (bits above index ignored)
//   resolve_mispred   1 = mispredicted, 0 = correct
//   save_state        to RAT: snapshot into save_page (same cycle as alloc)
//   save_page         to RAT: = alloc_page
//   restore_state     to RAT: registered 1-cycle restore pulse
//   restore_page      to RAT: page to restore from
//   if_id_flush       registered pulse coincident with restore_state
//   busy_map          valid bit per page
//   err_bad_resolve   sticky: resolve targeted a non-valid page
//
// Optional build macro
//   CKPT_STATS_EN     adds stat_mispred / stat_full_stall saturating counters
module rat_checkpoint_ctrl #(
  parameter int unsigned NUM_PAGES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_all,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  output logic [4:0]           alloc_page,
  input  logic                 resolve_valid,
  input  logic [4:0]           resolve_page,
  input  logic                 resolve_mispred,
  output logic                 save_state,
  output logic [4:0]           save_page,
  output logic                 restore_state,
  output logic [4:0]           restore_page,
  output logic                 if_id_flush,
  output logic [NUM_PAGES-1:0] busy_map,
`ifdef CKPT_STATS_EN
  output logic [31:0]          stat_mispred,
  output logic [31:0]          stat_full_stall,
`endif
  output logic                 err_bad_resolve
);

  localparam int unsigned PTR_W = $clog2(NUM_PAGES);

  logic [PTR_W:0]         r_head;
  logic [PTR_W:0]         r_tail;
  logic [NUM_PAGES-1:0]   r_valid;
  logic [NUM_PAGES-1:0]   r_done;
  logic                   r_restore_state;
  logic [4:0]             r_restore_page;
  logic                   r_if_id_flush;
  logic                   r_err;

  logic [PTR_W:0]         w_count;
  logic                   w_full;
  logic                   w_empty;
  logic [PTR_W-1:0]       w_head_idx;
  logic [PTR_W-1:0]       w_tail_idx;
  logic [PTR_W-1:0]       w_res_idx;
  logic [4:0]             w_res_page_pad;
  logic                   w_res_hit;
  logic                   w_mis_fire;
  logic                   w_ok_fire;
  logic                   w_bad_fire;
  logic                   w_alloc_fire;
  logic                   w_retire;
  logic [PTR_W-1:0]       w_off;
  logic [NUM_PAGES-1:0]   w_squash;
  logic [NUM_PAGES-1:0]   w_valid_nxt;
  logic [NUM_PAGES-1:0]   w_done_nxt;
  logic                   w_unused_rp_hi;

  assign w_count    = r_tail - r_head;
  assign w_full     = (w_count == (PTR_W+1)'(NUM_PAGES));
  assign w_empty    = (w_count == '0);
  assign w_head_idx = r_head[PTR_W-1:0];
  assign w_tail_idx = r_tail[PTR_W-1:0];
  assign w_res_idx  = resolve_page[PTR_W-1:0];
  assign w_res_hit  = r_valid[w_res_idx];
  assign w_unused_rp_hi = |(resolve_page >> PTR_W);

  assign w_mis_fire   = resolve_valid & resolve_mispred & w_res_hit & ~flush_all;
  assign w_ok_fire    = resolve_valid & ~resolve_mispred & w_res_hit & ~flush_all;
  assign w_bad_fire   = resolve_valid & ~w_res_hit & ~flush_all;
  assign w_alloc_fire = alloc_valid & ~w_full & ~w_mis_fire & ~flush_all;
  // Retiring the page being mispredicted would lose the restore source.
  assign w_retire     = ~w_empty & r_done[w_head_idx] &
                        ~(w_mis_fire & (w_head_idx == w_res_idx));

  // Age of the mispredicted page relative to head; everything at or beyond
  // that age is squashed. Pages outside the live window are already invalid,
  // so clearing them too is harmless.
  assign w_off = w_res_idx - w_head_idx;

  always_comb begin
    w_squash = '0;
    for (int unsigned i = 0; i < NUM_PAGES; i++) begin
      logic [PTR_W-1:0] rel;
      rel = PTR_W'(i) - w_head_idx;
      w_squash[i] = (rel >= w_off);
    end
  end

  always_comb begin
    w_res_page_pad = '0;
    w_res_page_pad[PTR_W-1:0] = w_res_idx;
    alloc_page = '0;
    alloc_page[PTR_W-1:0] = w_tail_idx;
  end

  always_comb begin
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    if (w_ok_fire) begin
      w_done_nxt[w_res_idx] = 1'b1;
    end
    if (w_retire) begin
      w_valid_nxt[w_head_idx] = 1'b0;
      w_done_nxt[w_head_idx]  = 1'b0;
    end
    if (w_mis_fire) begin
      w_valid_nxt = w_valid_nxt & ~w_squash;
      w_done_nxt  = w_done_nxt & ~w_squash;
    end
    if (w_alloc_fire) begin
      w_valid_nxt[w_tail_idx] = 1'b1;
      w_done_nxt[w_tail_idx]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_all) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_valid         <= '0;
      r_done          <= '0;
      r_restore_state <= 1'b0;
      r_restore_page  <= '0;
      r_if_id_flush   <= 1'b0;
      if (reset) begin
        r_err <= 1'b0;
      end
    end else begin
      r_valid         <= w_valid_nxt;
      r_done          <= w_done_nxt;
      r_head          <= r_head + (PTR_W+1)'(w_retire);
      // Tail rollback uses the pre-retire head: a same-cycle retire never
      // touches the squashed range, so the result is unchanged.
      if (w_mis_fire) begin
        r_tail <= r_head + {1'b0, w_off};
      end else begin
        r_tail <= r_tail + (PTR_W+1)'(w_alloc_fire);
      end
      r_restore_state <= w_mis_fire;
      r_if_id_flush   <= w_mis_fire;
      if (w_mis_fire) begin
        r_restore_page <= w_res_page_pad;
      end
      if (w_bad_fire) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef CKPT_STATS_EN
  logic [31:0] r_stat_mispred;
  logic [31:0] r_stat_full_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_mispred    <= '0;
      r_stat_full_stall <= '0;
    end else begin
      if (w_mis_fire && (r_stat_mispred != '1)) begin
        r_stat_mispred <= r_stat_mispred + 32'd1;
      end
      if (alloc_valid && w_full && (r_stat_full_stall != '1)) begin
        r_stat_full_stall <= r_stat_full_stall + 32'd1;
      end
    end
  end

  assign stat_mispred    = r_stat_mispred;
  assign stat_full_stall = r_stat_full_stall;
`endif

  assign alloc_ready     = ~w_full;
  assign save_state      = w_alloc_fire;
  assign save_page       = alloc_page;
  assign restore_state   = r_restore_state;
  assign restore_page    = r_restore_page;
  assign if_id_flush     = r_if_id_flush;
  assign busy_map        = r_valid;
  assign err_bad_resolve = r_err;

endmodule

// File: tb/tb_rat_checkpoint_ctrl.sv
// Scoreboard bench for rat_checkpoint_ctrl. The driver applies stimulus,
// derives the expected outputs for that cycle from a program-order list of
// live checkpoints, and queues them; a monitor compares on the falling edge.
module tb_rat_checkpoint_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush_all = 1'b0;
  logic         alloc_valid = 1'b0;
  logic         alloc_ready;
  logic [4:0]   alloc_page;
  logic         resolve_valid = 1'b0;
  logic [4:0]   resolve_page = '0;
  logic         resolve_mispred = 1'b0;
  logic         save_state;
  logic [4:0]   save_page;
  logic         restore_state;
  logic [4:0]   restore_page;
  logic         if_id_flush;
  logic [N-1:0] busy_map;
  logic         err_bad_resolve;

  always #5 clk = ~clk;

  rat_checkpoint_ctrl #(.NUM_PAGES(N)) dut (
    .clk(clk), .reset(reset), .flush_all(flush_all),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_page(alloc_page),
    .resolve_valid(resolve_valid), .resolve_page(resolve_page),
    .resolve_mispred(resolve_mispred),
    .save_state(save_state), .save_page(save_page),
    .restore_state(restore_state), .restore_page(restore_page),
    .if_id_flush(if_id_flush), .busy_map(busy_map),
    .err_bad_resolve(err_bad_resolve)
  );

  typedef struct {
    bit         ready;
    int         apage;
    bit         save;
    bit [N-1:0] busy;
    bit         rs;
    int         rpage;
    bit         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_err = 0;
  int   n_chk = 0;

  // Reference model: live checkpoints oldest-first with their done flags.
  int   m_q[$];
  bit   m_d[$];
  int   m_tail = 0;
  bit   m_rs = 0;
  int   m_rp = 0;
  bit   m_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    end
  endtask

  function automatic int find_page(input int p);
    foreach (m_q[k]) if (m_q[k] == p) return k;
    return -1;
  endfunction

  function automatic bit [N-1:0] busy_of();
    bit [N-1:0] b = '0;
    foreach (m_q[k]) b[m_q[k]] = 1'b1;
    return b;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("alloc_ready",     32'(alloc_ready),     32'(e.ready));
        chk("alloc_page",      32'(alloc_page),      32'(e.apage));
        chk("save_state",      32'(save_state),      32'(e.save));
        chk("save_page",       32'(save_page),       32'(e.apage));
        chk("busy_map",        32'(busy_map),        32'(e.busy));
        chk("restore_state",   32'(restore_state),   32'(e.rs));
        chk("if_id_flush",     32'(if_id_flush),     32'(e.rs));
        chk("restore_page",    32'(restore_page),    32'(e.rpage));
        chk("err_bad_resolve", 32'(err_bad_resolve), 32'(e.err));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; flush_all = 1'b0; alloc_valid = 1'b0;
    resolve_valid = 1'b0; resolve_mispred = 1'b0; resolve_page = '0;
    m_q.delete(); m_d.delete();
    m_tail = 0; m_rs = 0; m_rp = 0; m_err = 0;
  endtask

  task automatic step(input bit av, input bit rv, input logic [4:0] rpraw,
                      input bit mp, input bit fl);
    exp_t e;
    int p, idx;
    bit mis, alloc, ret;
    @(posedge clk); #1;
    reset = 1'b0;
    alloc_valid = av; resolve_valid = rv; resolve_page = rpraw;
    resolve_mispred = mp; flush_all = fl;
    p   = int'(rpraw) % N;
    idx = find_page(p);
    e.ready = (m_q.size() < N);
    e.apage = m_tail;
    e.busy  = busy_of();
    e.rs    = m_rs;
    e.rpage = m_rp;
    e.err   = m_err;
    mis   = rv && mp && (idx >= 0) && !fl;
    alloc = av && (m_q.size() < N) && !mis && !fl;
    e.save = alloc;
    exp_q.push_back(e);
    if (fl) begin
      m_q.delete(); m_d.delete();
      m_tail = 0; m_rs = 0; m_rp = 0;
    end else begin
      ret = (m_q.size() > 0) && m_d[0] && !(mis && idx == 0);
      if (rv && idx < 0) m_err = 1;
      if (rv && !mp && idx >= 0) m_d[idx] = 1;
      if (ret) begin
        void'(m_q.pop_front()); void'(m_d.pop_front());
        idx--;
      end
      if (mis) begin
        while (m_q.size() > idx) begin
          void'(m_q.pop_back()); void'(m_d.pop_back());
        end
        m_tail = p;
      end
      if (alloc) begin
        m_q.push_back(m_tail); m_d.push_back(1'b0);
        m_tail = (m_tail + 1) % N;
      end
      m_rs = mis;
      if (mis) m_rp = p;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 0, 0);
  endtask

  initial begin : driver
    logic [4:0] rp;
    do_reset();

    // three allocations from reset, then fill to full and stall
    for (int i = 0; i < 3; i++) step(1, 0, 5'd0, 0, 0);
    idle(1);
    for (int i = 0; i < 6; i++) step(1, 0, 5'd0, 0, 0);
    step(1, 1, 5'd0, 0, 0);
    step(1, 0, 5'd0, 0, 0);
    step(1, 0, 5'd0, 0, 0);
    idle(1);

    // mispredict page 2 with pages 0..4 live, then reuse of page 2
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 5'd0, 0, 0);
    step(1, 1, 5'd2, 1, 0);
    idle(1);
    step(1, 0, 5'd0, 0, 0);
    // in-order retire of 0 then 1, then drain to empty
    step(0, 1, 5'd1, 0, 0);
    step(0, 1, 5'd0, 0, 0);
    step(0, 1, 5'd2, 0, 0);
    idle(4);

    // wrap: head moves to 6, allocate 6,7,0,1, mispredict 7 (upper tag bit set)
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 5'd0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 5'(i), 0, 0);
    idle(7);
    for (int i = 0; i < 4; i++) step(1, 0, 5'd0, 0, 0);
    step(0, 1, 5'd15, 1, 0);
    idle(1);
    step(1, 0, 5'd0, 0, 0);

    // flush beats alloc and mispredict; later resolve of a dead page is an error
    for (int i = 0; i < 3; i++) step(1, 0, 5'd0, 0, 0);
    step(1, 1, 5'd0, 1, 1);
    step(0, 1, 5'd3, 0, 0);
    idle(2);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (m_q.size() > 0 && $urandom_range(0, 9) < 8)
        rp = 5'(m_q[$urandom_range(0, m_q.size() - 1)] + N * int'($urandom_range(0, 3)));
      else
        rp = 5'($urandom_range(0, 31));
      step($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), rp,
           $urandom_range(0, 99) < 15, $urandom_range(0, 49) == 0);
    end

    // reset clears the sticky error
    do_reset();
    idle(2);

    @(posedge clk); #1;
    alloc_valid = 1'b0; resolve_valid = 1'b0; flush_all = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
